// File: rtl/fc_layer_scheduler_if.sv
// Bundle between the FC layer scheduler and its surroundings (layers, ROM,
// MultAdder, host).
//   host    : start in; busy/done/error/digit out
//   layers  : l_done, l_addr, l_opr1/2 in; l_ena, l_rst_n, l_rom_data out
//   ROM     : data_from_rom in; addr_to_rom out
//   MultAdd : opr1_to_MultAdder, opr2_to_MultAdder out
// master = scheduler side, slave = environment side.
interface fc_layer_scheduler_if #(
  parameter int unsigned BIT = 16
);
  localparam int unsigned VW = 128 * BIT;

  logic              start;
  logic [2:0]        l_done;
  logic [32:0]       l_addr;
  logic [3*VW-1:0]   l_opr1;
  logic [3*VW-1:0]   l_opr2;
  logic [VW-1:0]     data_from_rom;
  logic [10*BIT-1:0] fc3_result;

  logic [2:0]        l_ena;
  logic [2:0]        l_rst_n;
  logic [3*VW-1:0]   l_rom_data;
  logic [10:0]       addr_to_rom;
  logic [VW-1:0]     opr1_to_MultAdder;
  logic [VW-1:0]     opr2_to_MultAdder;
  logic              busy;
  logic              done;
  logic              error;
  logic [3:0]        digit;

  modport master (
    input  start, l_done, l_addr, l_opr1, l_opr2, data_from_rom, fc3_result,
    output l_ena, l_rst_n, l_rom_data, addr_to_rom, opr1_to_MultAdder,
           opr2_to_MultAdder, busy, done, error, digit
  );

  modport slave (
    output start, l_done, l_addr, l_opr1, l_opr2, data_from_rom, fc3_result,
    input  l_ena, l_rst_n, l_rom_data, addr_to_rom, opr1_to_MultAdder,
           opr2_to_MultAdder, busy, done, error, digit
  );
endinterface

// File: rtl/fc_layer_scheduler.sv
// Sequencer for FC1..FC3: clears, enables and awaits each layer in turn,
// routes the shared ROM port and MultAdder to the active layer, then runs a
// sequential signed argmax over the FC3 outputs.
// Ports: clk, iRst (sync, active-high), bus (fc_layer_scheduler_if.master).
module fc_layer_scheduler #(
  parameter int unsigned BIT     = 16,
  parameter int unsigned TIMEOUT = 4096
) (
  input logic                   clk,
  input logic                   iRst,
  fc_layer_scheduler_if.master  bus
);
  localparam int unsigned VW   = 128 * BIT;
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_RUN, S_NEXT, S_ARGMAX, S_DONE, S_ERR
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             k_q, k_d;
  logic [WD_W-1:0]        cnt_q, cnt_d;
  logic [3:0]             idx_q, idx_d;
  logic signed [BIT-1:0]  best_q, best_d;
  logic [3:0]             best_idx_q, best_idx_d;
  logic [2:0]             l_ena_q, l_ena_d;
  logic [2:0]             l_rst_n_q, l_rst_n_d;
  logic [3*VW-1:0]        rom_q, rom_d;
  logic [10:0]            addr_q, addr_d;
  logic [VW-1:0]          opr1_q, opr1_d;
  logic [VW-1:0]          opr2_q, opr2_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic [3:0]             digit_q, digit_d;

  logic signed [BIT-1:0]  elem_c;
  logic                   take_c;

  // Next-state, routing and output computation
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    l_ena_d    = l_ena_q;
    l_rst_n_d  = l_rst_n_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    digit_d    = digit_q;
    addr_d     = '0;
    opr1_d     = '0;
    opr2_d     = '0;
    rom_d      = '0;

    elem_c = bus.fc3_result[BIT*idx_q +: BIT];
    // First element always loads; later ones only on strictly greater
    take_c = (idx_q == 4'd0) || (elem_c > best_q);

    // Shared resources follow the layer that was active last cycle; idle
    // layers see zero ROM data so they never mistake it for a response.
    if (state_q == S_CLR || state_q == S_RUN) begin
      addr_d                = bus.l_addr[11*k_q +: 11];
      opr1_d                = bus.l_opr1[VW*k_q +: VW];
      opr2_d                = bus.l_opr2[VW*k_q +: VW];
      rom_d[VW*k_q +: VW]   = bus.data_from_rom;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          state_d   = S_CLR;
          k_d       = 2'd0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          error_d   = 1'b0;
          l_ena_d   = 3'b001;
          l_rst_n_d = 3'b110;
        end
      end
      // Layers only honour reset while enabled, so both are asserted here
      S_CLR: begin
        if (cnt_q == WD_W'(1)) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          l_rst_n_d = 3'b111;
        end else begin
          cnt_d = cnt_q + WD_W'(1);
        end
      end
      // Done is checked first so it wins over a coincident timeout
      S_RUN: begin
        if (bus.l_done[k_q]) begin
          state_d = S_NEXT;
          l_ena_d = 3'b000;
        end else if (cnt_q == WD_W'(TIMEOUT - 1)) begin
          state_d = S_ERR;
          l_ena_d = 3'b000;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + WD_W'(1);
        end
      end
      S_NEXT: begin
        if (k_q == 2'd2) begin
          state_d = S_ARGMAX;
          idx_d   = 4'd0;
        end else begin
          state_d   = S_CLR;
          k_d       = k_q + 2'd1;
          cnt_d     = '0;
          l_ena_d   = 3'b001 << k_d;
          l_rst_n_d = ~(3'b001 << k_d);
        end
      end
      S_ARGMAX: begin
        if (take_c) begin
          best_d     = elem_c;
          best_idx_d = idx_q;
        end
        if (idx_q == 4'd9) begin
          state_d = S_DONE;
          digit_d = take_c ? idx_q : best_idx_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (iRst) begin
      state_q    <= S_IDLE;
      k_q        <= 2'd0;
      cnt_q      <= '0;
      idx_q      <= 4'd0;
      best_q     <= '0;
      best_idx_q <= 4'd0;
      l_ena_q    <= 3'b000;
      l_rst_n_q  <= 3'b111;
      rom_q      <= '0;
      addr_q     <= '0;
      opr1_q     <= '0;
      opr2_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      digit_q    <= 4'd0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      l_ena_q    <= l_ena_d;
      l_rst_n_q  <= l_rst_n_d;
      rom_q      <= rom_d;
      addr_q     <= addr_d;
      opr1_q     <= opr1_d;
      opr2_q     <= opr2_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      digit_q    <= digit_d;
    end
  end

  assign bus.l_ena             = l_ena_q;
  assign bus.l_rst_n           = l_rst_n_q;
  assign bus.l_rom_data        = rom_q;
  assign bus.addr_to_rom       = addr_q;
  assign bus.opr1_to_MultAdder = opr1_q;
  assign bus.opr2_to_MultAdder = opr2_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.error             = error_q;
  assign bus.digit             = digit_q;

endmodule

// File: tb/tb_fc_layer_scheduler.sv
// Bench for fc_layer_scheduler: layer models with programmable run length,
// an expected per-cycle trace derived from the sequencing rules, routing
// expectations from the previously driven inputs, and a reference argmax.
module tb_fc_layer_scheduler;
  localparam int unsigned BIT     = 16;
  localparam int unsigned VW      = 128 * BIT;
  localparam int unsigned TIMEOUT = 4096;

  typedef struct packed {
    logic [2:0] ena;
    logic [2:0] rstn;
    logic       busy;
    logic       done;
    logic       err;
    logic       act_v;
    logic [1:0] act;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fc_layer_scheduler_if #(.BIT(BIT)) bus ();
  fc_layer_scheduler #(.BIT(BIT), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .iRst (rst),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Layer models: count enabled, out-of-reset cycles; lrun=0 never finishes
  int         lrun [3];
  logic [7:0] lcnt [3];
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (bus.l_ena[k]) begin
        if (!bus.l_rst_n[k])         lcnt[k] <= 8'd0;
        else if (lcnt[k] != 8'hFF)   lcnt[k] <= lcnt[k] + 8'd1;
      end
    end
  end
  always_comb begin
    bus.l_done = 3'b000;
    for (int k = 0; k < 3; k++)
      bus.l_done[k] = (lrun[k] != 0) && (int'(lcnt[k]) >= lrun[k] - 1);
  end

  rec_t            exp_q[$];
  int              exp_digit;
  logic            prev_v;
  logic [1:0]      prev_act;
  logic [32:0]     prev_addr;
  logic [VW-1:0]   prev_data;
  logic [3*VW-1:0] prev_o1, prev_o2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] fold(input logic [VW-1:0] v);
    logic [63:0] r;
    logic [63:0] c;
    r = '0;
    for (int i = 0; i < int'(VW / 64); i++) begin
      c = v[i*64 +: 64];
      r = r ^ ((c << i) | (c >> (64 - i)));
    end
    return r;
  endfunction

  function automatic int ref_argmax(input logic [10*BIT-1:0] v);
    logic signed [BIT-1:0] e;
    int best_i, best_v;
    e = v[BIT-1:0];
    best_v = int'(e);
    best_i = 0;
    for (int i = 1; i < 10; i++) begin
      e = v[i*BIT +: BIT];
      if (int'(e) > best_v) begin
        best_v = int'(e);
        best_i = i;
      end
    end
    return best_i;
  endfunction

  function automatic rec_t mk(logic [2:0] ena, logic [2:0] rstn, logic busy,
                              logic done, logic err, logic act_v, logic [1:0] act);
    rec_t r;
    r = '{ena: ena, rstn: rstn, busy: busy, done: done, err: err, act_v: act_v, act: act};
    return r;
  endfunction

  // Expected observation after each clock edge, from the start edge onward
  task automatic build();
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      automatic logic [2:0] oh = 3'(1 << k);
      repeat (2) exp_q.push_back(mk(oh, ~oh, 1'b1, 1'b0, 1'b0, 1'b1, 2'(k)));
      if (lrun[k] == 0) begin
        repeat (TIMEOUT) exp_q.push_back(mk(oh, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 2'(k)));
        exp_q.push_back(mk(3'b000, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        return;
      end
      repeat (lrun[k]) exp_q.push_back(mk(oh, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 2'(k)));
      exp_q.push_back(mk(3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
    end
    repeat (10) exp_q.push_back(mk(3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
    exp_q.push_back(mk(3'b000, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0));
  endtask

  task automatic check_reset();
    chk("rst_status", 64'({bus.l_ena, bus.l_rst_n, bus.busy, bus.done, bus.error}),
        64'({3'b000, 3'b111, 3'b000}));
    chk("rst_digit", 64'(bus.digit), 64'd0);
    chk("rst_addr", 64'(bus.addr_to_rom), 64'd0);
    chk("rst_opr1", fold(bus.opr1_to_MultAdder), 64'd0);
    chk("rst_opr2", fold(bus.opr2_to_MultAdder), 64'd0);
    for (int s = 0; s < 3; s++) chk("rst_rom", fold(bus.l_rom_data[s*VW +: VW]), 64'd0);
    prev_v = 1'b0;
  endtask

  task automatic cycle_check(input rec_t r);
    logic [10:0]   ea;
    logic [VW-1:0] e1, e2, ed;
    chk("status", 64'({bus.l_ena, bus.l_rst_n, bus.busy, bus.done, bus.error}),
        64'({r.ena, r.rstn, r.busy, r.done, r.err}));
    ea = prev_v ? prev_addr[11*prev_act +: 11] : 11'd0;
    e1 = prev_v ? prev_o1[VW*prev_act +: VW] : '0;
    e2 = prev_v ? prev_o2[VW*prev_act +: VW] : '0;
    chk("addr", 64'(bus.addr_to_rom), 64'(ea));
    chk("opr1", fold(bus.opr1_to_MultAdder), fold(e1));
    chk("opr2", fold(bus.opr2_to_MultAdder), fold(e2));
    for (int s = 0; s < 3; s++) begin
      ed = (prev_v && int'(prev_act) == s) ? prev_data : '0;
      chk("rom_slice", fold(bus.l_rom_data[s*VW +: VW]), fold(ed));
    end
    if (r.done) chk("digit", 64'(bus.digit), 64'(exp_digit));
    prev_v   = r.act_v;
    prev_act = r.act;
  endtask

  task automatic drive_inputs(input bit directed, input rec_t r);
    logic [15:0] d16;
    prev_addr = 33'({$urandom(), $urandom()});
    d16 = 16'($urandom());
    if ($urandom_range(0, 7) == 0) d16 = 16'h0000;
    if (directed && r.act_v && r.act == 2'd1) begin
      prev_addr[21:11] = 11'h123;
      prev_addr[10:0]  = 11'h7FF;
      d16 = 16'hAAAA;
    end
    prev_data = {128{d16}};
    for (int k = 0; k < 3; k++) begin
      prev_o1[k*VW +: VW] = {64{32'($urandom())}};
      prev_o2[k*VW +: VW] = {64{32'($urandom())}};
    end
    bus.l_addr        = prev_addr;
    bus.data_from_rom = prev_data;
    bus.l_opr1        = prev_o1;
    bus.l_opr2        = prev_o2;
  endtask

  // One inference from an idle/terminal state; optional reset in FC3 RUN
  task automatic run_inf(input bit directed, input bit do_abort);
    int n;
    build();
    n = exp_q.size();
    exp_digit = ref_argmax(bus.fc3_result);
    prev_v = 1'b0;
    bus.start = 1'b1;
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      cycle_check(exp_q[j]);
      bus.start = (j < n - 1) && ($urandom_range(0, 3) == 0);
      if (do_abort && exp_q[j].act_v && exp_q[j].act == 2'd2 && exp_q[j].rstn == 3'b111) begin
        bus.start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset();
        rst = 1'b0;
        return;
      end
      drive_inputs(directed, exp_q[j]);
    end
    repeat ($urandom_range(1, 3)) begin
      @(posedge clk); #1;
      cycle_check(exp_q[n-1]);
      drive_inputs(1'b0, exp_q[n-1]);
    end
  endtask

  task automatic rand_fc3();
    logic [10*BIT-1:0] v;
    logic [BIT-1:0]    e;
    e = '0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0 || $urandom_range(0, 3) != 0) e = BIT'($urandom());
      v[i*BIT +: BIT] = e;
    end
    bus.fc3_result = v;
  endtask

  task automatic rand_runs();
    for (int k = 0; k < 3; k++) lrun[k] = int'($urandom_range(1, 8));
  endtask

  initial begin
    logic [10*BIT-1:0] v;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.l_addr = '0;
    bus.l_opr1 = '0;
    bus.l_opr2 = '0;
    bus.data_from_rom = '0;
    bus.fc3_result = '0;
    for (int k = 0; k < 3; k++) lrun[k] = 5;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;

    // Directed: 5-cycle layers, element 7 is the clear winner
    for (int i = 0; i < 10; i++) v[i*BIT +: BIT] = (i == 7) ? 16'h0300 : 16'h0010;
    bus.fc3_result = v;
    run_inf(1'b1, 1'b0);

    // All negative, -1 at indices 3 and 8
    for (int i = 0; i < 10; i++) v[i*BIT +: BIT] = BIT'(-int'($urandom_range(2, 32768)));
    v[3*BIT +: BIT] = 16'hFFFF;
    v[8*BIT +: BIT] = 16'hFFFF;
    bus.fc3_result = v;
    rand_runs();
    run_inf(1'b0, 1'b0);

    // FC2 hangs, then a clean restart
    rand_runs();
    lrun[1] = 0;
    rand_fc3();
    run_inf(1'b0, 1'b0);
    rand_runs();
    rand_fc3();
    run_inf(1'b0, 1'b0);

    // Reset during FC3, then a clean run
    rand_runs();
    rand_fc3();
    run_inf(1'b0, 1'b1);
    rand_runs();
    rand_fc3();
    run_inf(1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      rand_runs();
      rand_fc3();
      run_inf(1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
